// File: rtl/ascii_tx_formatter.sv
// ascii_tx_formatter: formats a status tag plus eight BCD digits as an ASCII line
// (tag, ':', digits MSD first, CR, LF) over a valid/ready byte stream.
// Optional feature: define ASCII_TX_ZERO_SUPPRESS_EN to skip leading '0' digits.
module ascii_tx_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  status_code,
    input  logic [31:0] value,
    output logic [7:0]  ascii_out,
    output logic        ascii_valid,
    input  logic        ascii_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ByteW  = 8;
    localparam int unsigned ValueW = 32;
    localparam int unsigned IdxW   = 3;

    localparam logic [ByteW-1:0] ChColon = 8'h3A;
    localparam logic [ByteW-1:0] ChCr    = 8'h0D;
    localparam logic [ByteW-1:0] ChLf    = 8'h0A;
    localparam logic [ByteW-1:0] ChStar  = 8'h2A;
    localparam logic [ByteW-1:0] ChZero  = 8'h30;
    localparam logic [ByteW-1:0] ChQuery = 8'h3F;
    localparam logic [IdxW-1:0]  IdxMsd  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_COLON,
        S_DIGITS,
        S_CR,
        S_LF
    } state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [ValueW-1:0]   value_q, value_d;
    logic [ByteW-1:0]    out_q, out_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                xfer;
    logic [IdxW-1:0]     first_idx;

    // Status code to tag character.
    function automatic logic [ByteW-1:0] tag_char(input logic [3:0] code);
        case (code)
            4'd1:    return 8'h41;
            4'd2:    return 8'h4E;
            4'd3:    return 8'h50;
            4'd4:    return 8'h58;
            4'd5:    return 8'h56;
            4'd6:    return 8'h49;
            4'd7:    return 8'h51;
            4'd8:    return 8'h43;
            default: return ChQuery;
        endcase
    endfunction

    // Select BCD digit i (0 = least significant).
    function automatic logic [3:0] nibble(input logic [ValueW-1:0] v, input logic [IdxW-1:0] i);
        logic [ValueW-1:0] s;
        s = v >> {i, 2'b00};
        return s[3:0];
    endfunction

    // BCD nibble to ASCII; non-decimal nibbles become '*'.
    function automatic logic [ByteW-1:0] digit_char(input logic [3:0] n);
        if (n <= 4'd9) begin
            return ChZero + {4'h0, n};
        end
        return ChStar;
    endfunction

`ifdef ASCII_TX_ZERO_SUPPRESS_EN
    // Highest non-zero digit position, or 0 when every digit is zero.
    function automatic logic [IdxW-1:0] lead_idx(input logic [ValueW-1:0] v);
        logic [IdxW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] != 4'h0) begin
                r = IdxW'(i);
            end
        end
        return r;
    endfunction

    // First digit emitted skips leading zeros.
    always_comb begin
        first_idx = lead_idx(value_q);
    end
`else
    // First digit emitted is always the most significant one.
    always_comb begin
        first_idx = IdxMsd;
    end
`endif

    assign xfer = valid_q & ascii_ready;

    // Next-state and output-register logic; stalled bytes hold via defaults.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        value_d = value_q;
        out_d   = out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TAG;
                    value_d = value;
                    out_d   = tag_char(status_code);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = IdxMsd;
                end
            end
            S_TAG: begin
                if (xfer) begin
                    state_d = S_COLON;
                    out_d   = ChColon;
                end
            end
            S_COLON: begin
                if (xfer) begin
                    state_d = S_DIGITS;
                    idx_d   = first_idx;
                    out_d   = digit_char(nibble(value_q, first_idx));
                end
            end
            S_DIGITS: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = S_CR;
                        out_d   = ChCr;
                    end else begin
                        idx_d = idx_q - 3'd1;
                        out_d = digit_char(nibble(value_q, idx_q - 3'd1));
                    end
                end
            end
            S_CR: begin
                if (xfer) begin
                    state_d = S_LF;
                    out_d   = ChLf;
                end
            end
            S_LF: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    out_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = IdxMsd;
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                idx_d   = IdxMsd;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IdxMsd;
            value_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ascii_out   = out_q;
    assign ascii_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/ascii_tx_formatter.md
ASCII_TX_FORMATTER -- requirements
Module: ascii_tx_formatter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: start  in  1  request to format one message; sampled only in IDLE.
REQ-004 SHALL have ports: status_code  in  4  status code (ACC_FOUND=1 .. INPUT_COMPLETE=8) selecting the tag character.
REQ-005 SHALL have ports: value  in  32  eight packed BCD digits, digit 7 in [31:28] is most significant.
REQ-006 SHALL have ports: ascii_out  out  8  current ASCII byte; ascii_valid  out  1  byte present; ascii_ready  in  1  sink accepts byte.
REQ-007 SHALL have ports: busy  out  1  message in progress; done  out  1  one-cycle pulse at message end.
REQ-008 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-009 SHALL capture status_code and value into internal registers on the cycle start=1 in IDLE; later input changes SHALL not affect the message.
REQ-010 SHALL ignore start while busy=1; no queuing.
REQ-011 SHALL run FSM IDLE -> TAG -> COLON -> DIGITS -> CR -> LF -> IDLE; each non-IDLE state advances only on a transfer (ascii_valid=1 and ascii_ready=1 in the same cycle).
REQ-012 SHALL emit the sequence: tag, ':' (0x3A), digit characters MSD first, 0x0D, 0x0A.
REQ-013 SHALL map tags: 1->'A'(0x41), 2->'N'(0x4E), 3->'P'(0x50), 4->'X'(0x58), 5->'V'(0x56), 6->'I'(0x49), 7->'Q'(0x51), 8->'C'(0x43), any other code->'?'(0x3F).
REQ-014 SHALL convert digit nibbles 0-9 to 0x30+nibble; nibbles 0xA-0xF SHALL emit '*' (0x2A).
REQ-015 SHALL keep a 3-bit digit index counting 7 down to 0; DIGITS exits to CR on transfer of index 0 (no wrap).
REQ-016 SHALL assert ascii_valid starting the cycle after start is accepted (latency 1) with the tag byte.
REQ-017 SHALL hold ascii_out and ascii_valid stable while ascii_valid=1 and ascii_ready=0.
REQ-018 SHALL keep ascii_valid=1 continuously from tag through LF; with ascii_ready tied high a message takes exactly 12 transfer cycles (unsuppressed).
REQ-019 SHALL register all outputs; ascii_valid SHALL not depend combinationally on ascii_ready.
REQ-020 SHALL drive busy=1 from the cycle after start acceptance until the LF transfer, inclusive.
REQ-021 SHALL pulse done=1 for exactly one cycle, the cycle after the LF transfer, with FSM in IDLE; start in that cycle SHALL be accepted.
REQ-022 SHALL drive ascii_out=0x00 whenever ascii_valid=0.

Reset
REQ-023 SHALL on rst=1 at a clock edge force IDLE, ascii_valid=0, ascii_out=0x00, busy=0, done=0, digit index=7, captured registers=0.
REQ-024 SHALL abort any message on rst mid-operation, including a stalled byte; no done pulse SHALL follow.
REQ-025 SHALL give rst priority over start in the same cycle.

Configuration
REQ-026 SHALL, with macro ASCII_TX_ZERO_SUPPRESS_EN defined, skip leading '0' digits, always emitting at least digit 0; all-zero value emits a single '0'.
REQ-027 SHALL, without ASCII_TX_ZERO_SUPPRESS_EN, emit all eight digits including leading zeros.
REQ-028 SHALL, with suppression, treat a '*' nibble as non-zero (ends suppression).

Verification
REQ-029 SHALL check: rst, ready=1, start with code=1, value=0x00001234 -> bytes 41 3A 30 30 30 30 31 32 33 34 0D 0A, done one cycle after 0A (macro off).
REQ-030 SHALL check: same stimulus with ASCII_TX_ZERO_SUPPRESS_EN -> 41 3A 31 32 33 34 0D 0A; value=0 -> 41 3A 30 0D 0A.
REQ-031 SHALL check: code=4, value=0x9A000000, ready toggling 1/0 every cycle -> 58 3A 39 2A 30 30 30 30 30 30 0D 0A, each byte stable across stalls.
REQ-032 SHALL check: start pulsed again mid-message with code=7 -> ignored; output matches first message only.
REQ-033 SHALL check: rst asserted while stalled on digit 3 -> next cycle valid=0, busy=0, out=0x00; no done; new start code=0xF yields tag 3F.
REQ-034 SHALL check: start held high through done cycle -> second message begins with tag one cycle after done.
